// File: rtl/gin_bus_driver.sv
// Initiator end of the PE multicast caster bus: flush, weight load, ifmap/psum
// broadcast, then wait for the aggregated caster VALID before signalling done.
module gin_bus_driver #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_COL    = 4,
   parameter int BUF_DEPTH  = 16,
   parameter int CNT_W      = 16,
   localparam int ID_W      = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [7:0]              cfg_kernel_size,
   input  logic [ID_W-1:0]         cfg_tag,
   input  logic [CNT_W-1:0]        cfg_num_beats,
   input  logic                    w_valid,
   output logic                    w_ready,
   input  logic [DATA_WIDTH-1:0]   w_data,
   input  logic                    x_valid,
   output logic                    x_ready,
   input  logic [DATA_WIDTH-1:0]   x_ifmap,
   input  logic [2*DATA_WIDTH-1:0] x_psum,
   input  logic [ID_W-1:0]         x_id,
   output logic                    bus_flush,
   output logic [ID_W-1:0]         bus_tag,
   output logic [7:0]              bus_kernel_size,
   output logic [DATA_WIDTH-1:0]   bus_fltr_data,
   output logic [DATA_WIDTH-1:0]   bus_ifmap_data,
   output logic [2*DATA_WIDTH-1:0] bus_psum_data,
   output logic [ID_W-1:0]         bus_id,
   output logic                    bus_caster_en,
   output logic                    bus_ready,
   input  logic                    bus_flush_busy,
   input  logic                    bus_valid,
   output logic                    busy,
   output logic                    done
);

   typedef enum logic [2:0] {
      S_IDLE, S_FLUSH, S_LOAD_W, S_WAIT_FB, S_STREAM, S_DRAIN, S_DONE
   } state_t;

   localparam logic [7:0] KS_MAX = 8'(BUF_DEPTH);

   state_t           state;
   logic [7:0]       wcnt;
   logic [CNT_W-1:0] bcnt;
   logic [1:0]       settle;
   logic [7:0]       ks_clamped;

   always_comb begin
      ks_clamped = (cfg_kernel_size > KS_MAX) ? KS_MAX : cfg_kernel_size;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state           <= S_IDLE;
         wcnt            <= '0;
         bcnt            <= '0;
         settle          <= '0;
         cfg_ready       <= 1'b1;
         w_ready         <= 1'b0;
         x_ready         <= 1'b0;
         bus_flush       <= 1'b0;
         bus_tag         <= '0;
         bus_kernel_size <= '0;
         bus_fltr_data   <= '0;
         bus_ifmap_data  <= '0;
         bus_psum_data   <= '0;
         bus_id          <= '0;
         bus_caster_en   <= 1'b0;
         bus_ready       <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
      end else begin
         bus_flush     <= 1'b0;
         bus_caster_en <= 1'b0;
         done          <= 1'b0;
         if (settle != '0) settle <= settle - 2'd1;

         case (state)
            S_IDLE: begin
               if (cfg_valid) begin
                  wcnt            <= ks_clamped;
                  bus_kernel_size <= ks_clamped;
                  bus_tag         <= cfg_tag;
                  bcnt            <= cfg_num_beats;
                  bus_flush       <= 1'b1;
                  cfg_ready       <= 1'b0;
                  busy            <= 1'b1;
                  state           <= S_FLUSH;
               end
            end
            S_FLUSH: begin
               // multicasters raise flush_busy a cycle late; hold off sampling it
               settle <= 2'd1;
               if (wcnt != '0) begin
                  w_ready <= 1'b1;
                  state   <= S_LOAD_W;
               end else begin
                  state   <= S_WAIT_FB;
               end
            end
            S_LOAD_W: begin
               if (w_valid && w_ready) begin
                  bus_fltr_data <= w_data;
                  wcnt          <= wcnt - 8'd1;
                  if (wcnt == 8'd1) begin
                     w_ready <= 1'b0;
                     state   <= S_WAIT_FB;
                  end
               end
            end
            S_WAIT_FB: begin
               if (settle == '0 && !bus_flush_busy) begin
                  if (bcnt != '0) begin
                     x_ready   <= 1'b1;
                     bus_ready <= 1'b1;
                     state     <= S_STREAM;
                  end else begin
                     done      <= 1'b1;
                     state     <= S_DONE;
                  end
               end
            end
            S_STREAM: begin
               if (x_valid && x_ready) begin
                  bus_caster_en  <= 1'b1;
                  bus_ifmap_data <= x_ifmap;
                  bus_psum_data  <= x_psum;
                  bus_id         <= x_id;
                  bcnt           <= bcnt - CNT_W'(1);
                  if (bcnt == CNT_W'(1)) begin
                     x_ready <= 1'b0;
                     state   <= S_DRAIN;
                  end else begin
                     x_ready <= ~bus_flush_busy;
                  end
               end else begin
                  x_ready <= ~bus_flush_busy;
               end
            end
            S_DRAIN: begin
               if (bus_valid) begin
                  bus_ready <= 1'b0;
                  done      <= 1'b1;
                  state     <= S_DONE;
               end
            end
            S_DONE: begin
               cfg_ready <= 1'b1;
               busy      <= 1'b0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
